// File: rtl/stream_demux_pkg.sv
// Shared types for the 1:2 stream demultiplexer.
// Skid-buffer occupancy states and the port count.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } skid_state_t;

  localparam int NUM_PORTS = 2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer for one demux output port.
// full is registered state only, so it never depends on out_ready.
module skid_buf2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             pop;

  assign out_valid = (state != EMPTY);
  assign full      = (state == TWO);
  assign out_data  = main_q;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) state <= ONE;
        ONE: begin
          if (push && !pop) state <= TWO;
          else if (!push && pop) state <= EMPTY;
        end
        TWO: if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Payload is not reset; state alone decides validity.
  always_ff @(posedge clk) begin
    unique case (state)
      EMPTY: if (push) main_q <= push_data;
      ONE: begin
        if (push && pop) main_q <= push_data;
        else if (push) skid_q <= push_data;
      end
      TWO: if (pop) main_q <= skid_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/stream_demux1_2.sv
// Registered 1:2 valid/ready stream demux with per-port skid buffers.
// Define STREAM_DEMUX_STATS_EN to add per-port popped-beat counters.
module stream_demux1_2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic [1:0]            out_valid,
  input  logic [1:0]            out_ready,
  output logic [1:0][WIDTH-1:0] out_data
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [1:0][15:0]      beat_count
`endif
);

  logic [1:0] full;
  logic [1:0] push;
  logic       accept;

  // Only the selected port's occupancy gates the producer.
  assign in_ready = reset_n && !full[in_sel];
  assign accept   = in_valid && in_ready;
  assign push     = {accept & in_sel, accept & ~in_sel};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    skid_buf2 #(
      .WIDTH(WIDTH)
    ) u_buf (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push[p]),
      .push_data(in_data),
      .full     (full[p]),
      .out_valid(out_valid[p]),
      .out_ready(out_ready[p]),
      .out_data (out_data[p])
    );
  end

`ifdef STREAM_DEMUX_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_count <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (out_valid[p] && out_ready[p])
          beat_count[p] <= beat_count[p] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux1_2.sv
// Self-checking bench for stream_demux1_2.
// Directed scenarios plus randomized traffic against a queue model.
module tb_stream_demux1_2;

  localparam int W = 64;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic               in_sel;
  logic [W-1:0]       in_data;
  logic [1:0]         out_valid;
  logic [1:0]         out_ready;
  logic [1:0][W-1:0]  out_data;
`ifdef STREAM_DEMUX_STATS_EN
  logic [1:0][15:0]   beat_count;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];

  always #5 clk = ~clk;

  stream_demux1_2 #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .beat_count(beat_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b0;
    in_data = '0;
    out_ready = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    compared++;
    if (out_valid !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_valid got %b exp 00", out_valid);
    end
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ready0 got %b exp 0", in_ready);
    end
    in_sel = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ready1 got %b exp 0", in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL release_ready got %b exp 1", in_ready);
    end
    tick();
  endtask

  task automatic test_routing();
    in_valid = 1'b1;
    in_sel = 1'b0;
    in_data = 64'hA;
    out_ready = 2'b11;
    tick();
    compared++;
    if (out_valid !== 2'b01 || out_data[0] !== 64'hA) begin
      mismatched++;
      $display("FAIL route_p0 got v=%b d=%h exp v=01 d=a",
               out_valid, out_data[0]);
    end
    in_sel = 1'b1;
    in_data = 64'hB;
    tick();
    compared++;
    if (out_valid !== 2'b10 || out_data[1] !== 64'hB) begin
      mismatched++;
      $display("FAIL route_p1 got v=%b d=%h exp v=10 d=b",
               out_valid, out_data[1]);
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (out_valid !== 2'b00) begin
      mismatched++;
      $display("FAIL route_idle got %b exp 00", out_valid);
    end
  endtask

  task automatic test_skid_fill();
    logic [W-1:0] got[$];
    out_ready = 2'b00;
    in_valid = 1'b1;
    in_sel = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      in_data = W'(b);
      #1;
      compared++;
      if (in_ready !== (b < 3)) begin
        mismatched++;
        $display("FAIL skid_ready beat %0d got %b exp %b",
                 b, in_ready, (b < 3));
      end
      tick();
    end
    out_ready = 2'b01;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid[0]) got.push_back(out_data[0]);
      if (in_valid && in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    compared++;
    if (got.size() != 3) begin
      mismatched++;
      $display("FAIL skid_count got %0d exp 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (i >= got.size() || got[i] !== W'(i + 1)) begin
        mismatched++;
        $display("FAIL skid_order idx %0d got %h exp %0d",
                 i, (i < got.size()) ? got[i] : '0, i + 1);
      end
    end
  endtask

  task automatic test_push_pop();
    out_ready = 2'b00;
    in_valid = 1'b1;
    in_sel = 1'b0;
    in_data = 64'd5;
    tick();
    compared++;
    if (out_data[0] !== 64'd5) begin
      mismatched++;
      $display("FAIL pp_hold got %h exp 5", out_data[0]);
    end
    in_data = 64'd6;
    out_ready = 2'b01;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL pp_ready got %b exp 1", in_ready);
    end
    tick();
    compared++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 64'd6) begin
      mismatched++;
      $display("FAIL pp_replace got v=%b d=%h exp v=1 d=6",
               out_valid[0], out_data[0]);
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (out_valid[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL pp_one got %b exp 0", out_valid[0]);
    end
  endtask

  task automatic test_independence();
    out_ready = 2'b00;
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_data = 64'h21;
    tick();
    in_data = 64'h22;
    tick();
    in_sel = 1'b0;
    out_ready = 2'b01;
    for (int k = 0; k < 10; k++) begin
      in_data = 64'h100 + W'(k);
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL ind_ready beat %0d got %b exp 1", k, in_ready);
      end
      tick();
      compared++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== 64'h100 + W'(k)) begin
        mismatched++;
        $display("FAIL ind_p0 beat %0d got v=%b d=%h exp %h",
                 k, out_valid[0], out_data[0], 64'h100 + W'(k));
      end
      compared++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== 64'h21) begin
        mismatched++;
        $display("FAIL ind_p1 beat %0d got v=%b d=%h exp 21",
                 k, out_valid[1], out_data[1]);
      end
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (out_valid !== 2'b10) begin
      mismatched++;
      $display("FAIL ind_end got %b exp 10", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1;
    in_sel = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 2'b00 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst got v=%b r=%b exp v=00 r=0",
               out_valid, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    compared++;
    if (out_valid !== 2'b00) begin
      mismatched++;
      $display("FAIL midrst_after got %b exp 00", out_valid);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_v;
    logic       exp_r;
    logic       took;
    mq0.delete();
    mq1.delete();
    in_valid = 1'b0;
    took = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_sel = 1'($urandom_range(0, 1));
        in_data = {$urandom, $urandom};
      end
      out_ready = 2'($urandom_range(0, 3));
      #2;
      exp_v = {mq1.size() != 0, mq0.size() != 0};
      exp_r = (in_sel ? mq1.size() : mq0.size()) < 2;
      compared++;
      if (out_valid !== exp_v) begin
        mismatched++;
        $display("FAIL rnd_valid cyc %0d got %b exp %b", c, out_valid, exp_v);
      end
      compared++;
      if (in_ready !== exp_r) begin
        mismatched++;
        $display("FAIL rnd_ready cyc %0d got %b exp %b", c, in_ready, exp_r);
      end
      if (exp_v[0]) begin
        compared++;
        if (out_data[0] !== mq0[0]) begin
          mismatched++;
          $display("FAIL rnd_d0 cyc %0d got %h exp %h", c, out_data[0], mq0[0]);
        end
      end
      if (exp_v[1]) begin
        compared++;
        if (out_data[1] !== mq1[0]) begin
          mismatched++;
          $display("FAIL rnd_d1 cyc %0d got %h exp %h", c, out_data[1], mq1[0]);
        end
      end
      took = in_valid && exp_r;
      if (exp_v[0] && out_ready[0]) void'(mq0.pop_front());
      if (exp_v[1] && out_ready[1]) void'(mq1.pop_front());
      if (took) begin
        if (in_sel) mq1.push_back(in_data);
        else mq0.push_back(in_data);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

`ifdef STREAM_DEMUX_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0;
    in_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_data = 64'h77;
    out_ready = 2'b11;
    repeat (65537) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    compared++;
    if (beat_count[1] !== 16'd1 || beat_count[0] !== 16'd0) begin
      mismatched++;
      $display("FAIL stats_wrap got %0d/%0d exp 0/1",
               beat_count[0], beat_count[1]);
    end
    in_valid = 1'b1;
    in_sel = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    compared++;
    if (beat_count !== '0) begin
      mismatched++;
      $display("FAIL stats_reset got %h exp 0", beat_count);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_skid_fill();
    test_push_pop();
    test_independence();
    test_reset_midstream();
    test_random();
`ifdef STREAM_DEMUX_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_demux1_2.md
# stream_demux1_2

Registered 1-to-2 stream demultiplexer with valid/ready handshaking: the write-side counterpart of the datapath's 2:1 select mux. Each accepted beat from a single producer is routed, by a per-beat select bit, to one of two consumer ports, such as the writeback or forwarding destinations in the pipelined CPU. Each output port has a 2-entry skid buffer, so one output stalling never drops data, and full throughput is sustained when consumers are ready.

## Interface
Parameters:
- WIDTH, 64, payload width in bits.

Ports:
- clk  input  1  rising-edge clock; one clock, all state in this domain.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts a beat this cycle.
- in_sel  input  1  destination port of the current beat; 0 → port 0, 1 → port 1.
- in_data  input  WIDTH  payload.
- out_valid  output  [1:0]  per-port beat available.
- out_ready  input  [1:0]  per-port consumer accepts.
- out_data  output  [1:0][WIDTH-1:0]  per-port payload, packed as index [port][bit].

## Operation
- Transfer rule: a transfer occurs on any edge where valid && ready, on either side.
  - Producer: in_valid, in_sel and in_data stay stable until accepted.
  - Consumer: out_data[p] stays stable while out_valid[p] && !out_ready[p].
- Each port p holds a buffer with three states:
  - EMPTY: out_valid[p]=0.
  - ONE: main register valid.
  - TWO: main and skid registers both valid.
- in_ready = reset_n && (state[in_sel] != TWO). This is a combinational function of in_sel and registered state only. There is no combinational path from out_ready to in_ready.
- Per-port transitions, where push = accept with in_sel==p and pop = out_valid[p] && out_ready[p]:
  - EMPTY + push → ONE; in_data is loaded into main.
  - ONE + push, no pop → TWO; in_data is loaded into skid.
  - ONE + push + pop → ONE; main is replaced by in_data.
  - ONE + pop, no push → EMPTY.
  - TWO + pop → ONE; skid moves to main. A push cannot happen because in_ready is 0.
  - All other cases hold state.
- Ordering: beats to the same port leave in acceptance order. There is no ordering guarantee between ports.
- Head-of-line blocking: a beat targeting a full port stalls the input. Beats queued for the other port still drain.
- Payload registers are not reset; only state is.

## Timing
- Reset (reset_n low, asynchronous):
  - Both ports go to EMPTY.
  - out_valid = 2'b00 and in_ready = 0 immediately.
  - After release, in_ready = 1 in the first cycle.
- Latency: a beat accepted at edge N appears on out_valid/out_data at edge N+1, when its port was EMPTY or popped in the same cycle.
- Throughput: 1 beat/cycle, sustained indefinitely, when the selected port's out_ready is held high.
- Stall capacity: 2 beats per port. The third consecutive beat to a stalled port sees in_ready=0.
- Reset mid-operation: buffered beats are discarded; no partial beat is ever presented.

## Configuration
- STREAM_DEMUX_STATS_EN defined:
  - Adds output ports beat_count [1:0][15:0], per-port counters of popped beats.
  - Counters increment on each pop, wrap from 16'hFFFF to 0, and reset to 0.
- STREAM_DEMUX_STATS_EN undefined: the ports and counters do not exist. Routing and handshake behaviour is identical in both builds.

## Structure
- Package stream_demux_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t.
  - localparam NUM_PORTS = 2.
- Sub-module skid_buf2 #(WIDTH): one per port, instantiated in a generate loop. Its interface is push, push_data, full, out_valid, out_ready, out_data, clk and reset_n.
- The top level contains only the sel decode, in_ready gating and the optional counters.

## Test plan
- Reset: hold reset_n=0 with in_valid=1 → out_valid=00 and in_ready=0. Release → in_ready=1 in the first cycle.
- Routing: beats 0xA (sel 0) and 0xB (sel 1) on consecutive cycles, both out_ready=1 → port0 shows 0xA at cycle+1 and port1 shows 0xB at cycle+2, one cycle each.
- Skid fill: out_ready[0]=0, beats 1,2,3 all to sel 0 → beats 1 and 2 accepted, in_ready=0 on beat 3. Raise out_ready[0] → port0 delivers 1,2,3 in order, with no loss or duplication.
- Simultaneous push/pop: port0 in ONE holding 5, push 6 and pop in the same cycle → next cycle out_data[0]=6 and state stays ONE.
- Independence: port1 stalled holding 2 beats while 10 beats stream to port0 with out_ready[0]=1 → all 10 delivered back-to-back. Port1 keeps out_valid=1 with unchanged data.
- Stats (macro defined): 65537 pops on port1 → beat_count[1]=1 (wrapped), beat_count[0]=0. Assert reset_n low mid-stream → both counters read 0.
